// File: rtl/grid_update_receiver_pkg.sv
// Shared types for the maze grid update receiver.
// Frame layout, command codes, cell states, FSM encoding.
package grid_update_receiver_pkg;

  localparam int ROWS_DEF    = 4;
  localparam int COLS_DEF    = 5;
  localparam int TIMEOUT_DEF = 25000;
  localparam int FRAME_W     = 8;

  localparam int F_PAR = 7;
  localparam int F_ROW = 5;
  localparam int F_COL = 2;
  localparam int F_ST  = 0;

  localparam logic [2:0] CMD_COL  = 3'd7;
  localparam logic [1:0] CLR_ROW  = 2'd0;
  localparam logic [1:0] DONE_ROW = 2'd3;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    WALL     = 2'd1,
    VISITED  = 2'd2,
    TREASURE = 2'd3
  } cell_t;

  typedef struct packed {
    logic       par;
    logic [1:0] row;
    logic [2:0] col;
    cell_t      st;
  } frame_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    CHECK = 3'd2,
    WRITE = 3'd3,
    DRAIN = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ACT_ERR  = 2'd0,
    ACT_CELL = 2'd1,
    ACT_CLR  = 2'd2,
    ACT_DONE = 2'd3
  } act_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with rise/fall detect.
// Ports: clk, rst_n (sync), din -> level, rise, fall.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sh;

  always_ff @(posedge clk) begin
    if (!rst_n) sh <= '0;
    else        sh <= {sh[1:0], din};
  end

  assign level = sh[1];
  assign rise  = sh[1] & ~sh[2];
  assign fall  = ~sh[1] & sh[2];

endmodule

// File: rtl/grid_update_receiver.sv
// Serial maze-cell update receiver with 4x5 grid store.
// Ports: CLOCK, RESET, SER_*, RD_ROW/COL -> RD_DATA, UPDATE, DONE, ERR_COUNT.
module grid_update_receiver
  import grid_update_receiver_pkg::*;
#(
  parameter int ROWS    = ROWS_DEF,
  parameter int COLS    = COLS_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       SER_CLK,
  input  logic       SER_DATA,
  input  logic       SER_EN,
  input  logic [1:0] RD_ROW,
  input  logic [2:0] RD_COL,
  output logic [1:0] RD_DATA,
  output logic       UPDATE,
  output logic       DONE,
  output logic [7:0] ERR_COUNT
);

  localparam int NCELL = ROWS * COLS;
  localparam int IW    = $clog2(NCELL);
  localparam int TW    = $clog2(TIMEOUT + 1);

  logic c_lvl, c_rise, c_fall;
  logic d_lvl, d_rise, d_fall;
  logic e_lvl, e_rise, e_fall;

  sync_edge u_clk (
    .clk(CLOCK), .rst_n(RESET), .din(SER_CLK),
    .level(c_lvl), .rise(c_rise), .fall(c_fall)
  );
  sync_edge u_dat (
    .clk(CLOCK), .rst_n(RESET), .din(SER_DATA),
    .level(d_lvl), .rise(d_rise), .fall(d_fall)
  );
  sync_edge u_en (
    .clk(CLOCK), .rst_n(RESET), .din(SER_EN),
    .level(e_lvl), .rise(e_rise), .fall(e_fall)
  );

  logic unused_ok;
  assign unused_ok = &{1'b0, c_lvl, d_rise, d_fall};

  state_t         state, state_d;
  frame_t         shreg;
  logic [3:0]     bitcnt;
  logic [TW-1:0]  tmo;
  act_t           act, act_d;
  cell_t          cells [NCELL];

  logic tmo_hit;
  logic cell_we, grid_clr, done_set, err_inc;

  assign tmo_hit = (tmo == TW'(TIMEOUT));

  // Frame classification, evaluated in CHECK.
  logic frame_ok, in_range, cell_ok, clr_ok, done_ok;

  always_comb begin
    frame_ok = (bitcnt == 4'd8) && (^shreg);
    in_range = (int'(shreg.col) < COLS) &&
               (int'(shreg.row) < ROWS);
    cell_ok  = frame_ok && in_range;
    clr_ok   = frame_ok && shreg.col == CMD_COL &&
               shreg.row == CLR_ROW;
    done_ok  = frame_ok && shreg.col == CMD_COL &&
               shreg.row == DONE_ROW;
    act_d    = ACT_ERR;
    unique case (1'b1)
      cell_ok: act_d = ACT_CELL;
      clr_ok:  act_d = ACT_CLR;
      done_ok: act_d = ACT_DONE;
      default: act_d = ACT_ERR;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:  if (e_rise) state_d = SHIFT;
      SHIFT: begin
        if (e_fall)       state_d = CHECK;
        else if (tmo_hit) state_d = DRAIN;
      end
      CHECK: state_d = WRITE;
      WRITE: state_d = IDLE;
      DRAIN: if (!e_lvl) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cell_we  = (state == WRITE) && (act == ACT_CELL);
    grid_clr = (state == WRITE) && (act == ACT_CLR);
    done_set = (state == WRITE) && (act == ACT_DONE);
    err_inc  = ((state == WRITE) && (act == ACT_ERR)) ||
               ((state == SHIFT) && !e_fall && tmo_hit);
    UPDATE   = cell_we || grid_clr;
  end

  // Clock edges coinciding with the enable fall are dropped.
  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      shreg  <= '0;
      bitcnt <= '0;
      tmo    <= '0;
      act    <= ACT_ERR;
    end else begin
      unique case (state)
        IDLE: begin
          tmo <= '0;
          if (e_rise) begin
            shreg  <= '0;
            bitcnt <= '0;
          end
        end
        SHIFT: begin
          if (!e_fall) begin
            if (c_rise) begin
              shreg <= frame_t'({shreg[FRAME_W-2:0], d_lvl});
              if (bitcnt != 4'd9) bitcnt <= bitcnt + 4'd1;
            end
            if (c_rise || c_fall) tmo <= '0;
            else                  tmo <= tmo + TW'(1);
          end
        end
        CHECK: act <= act_d;
        default: ;
      endcase
    end
  end

  logic [IW-1:0] wr_idx, rd_idx;
  logic          rd_ok;

  always_comb begin
    wr_idx = IW'(int'(shreg.row) * COLS + int'(shreg.col));
    rd_idx = IW'(int'(RD_ROW) * COLS + int'(RD_COL));
    rd_ok  = (int'(RD_ROW) < ROWS) && (int'(RD_COL) < COLS);
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      for (int i = 0; i < NCELL; i++) cells[i] <= EMPTY;
      RD_DATA   <= '0;
      DONE      <= 1'b0;
      ERR_COUNT <= '0;
    end else begin
      if (grid_clr)
        for (int i = 0; i < NCELL; i++) cells[i] <= EMPTY;
      else if (cell_we)
        cells[wr_idx] <= shreg.st;
      RD_DATA <= rd_ok ? cells[rd_idx] : EMPTY;
      if (done_set) DONE <= 1'b1;
      if (err_inc && ERR_COUNT != 8'hFF)
        ERR_COUNT <= ERR_COUNT + 8'd1;
    end
  end

endmodule

// File: tb/tb_grid_update_receiver.sv
// Directed bench for grid_update_receiver.
// Bit-bangs frames and checks grid, flags and error count.
module tb_grid_update_receiver;

  localparam int TMO = 300;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b0;
  logic       SER_CLK = 1'b0;
  logic       SER_DATA = 1'b0;
  logic       SER_EN = 1'b0;
  logic [1:0] RD_ROW = '0;
  logic [2:0] RD_COL = '0;
  logic [1:0] RD_DATA;
  logic       UPDATE;
  logic       DONE;
  logic [7:0] ERR_COUNT;

  grid_update_receiver #(.TIMEOUT(TMO)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .SER_CLK(SER_CLK), .SER_DATA(SER_DATA),
    .SER_EN(SER_EN),
    .RD_ROW(RD_ROW), .RD_COL(RD_COL),
    .RD_DATA(RD_DATA), .UPDATE(UPDATE),
    .DONE(DONE), .ERR_COUNT(ERR_COUNT)
  );

  always #5 CLOCK = ~CLOCK;

  int n_chk = 0;
  int n_pass = 0;
  int upd_cnt = 0;

  always @(negedge CLOCK) if (UPDATE) upd_cnt++;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic bits(input logic [8:0] f, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      SER_DATA = f[i];
      cyc(5);
      SER_CLK = 1'b1;
      cyc(5);
      SER_CLK = 1'b0;
    end
  endtask

  task automatic send(input logic [8:0] f, input int n);
    SER_EN = 1'b1;
    cyc(6);
    bits(f, n);
    cyc(5);
    SER_EN = 1'b0;
    cyc(12);
  endtask

  task automatic rd(input logic [1:0] r, input logic [2:0] c,
                    output logic [1:0] v);
    @(negedge CLOCK);
    RD_ROW = r;
    RD_COL = c;
    @(negedge CLOCK);
    v = RD_DATA;
  endtask

  logic [1:0] v;
  int u0;
  int nz;

  initial begin
    cyc(5);
    chk("rst_rd", RD_DATA, 0);
    chk("rst_upd", UPDATE, 0);
    chk("rst_done", DONE, 0);
    chk("rst_err", ERR_COUNT, 0);
    RESET = 1'b1;
    cyc(3);

    u0 = upd_cnt;
    send(9'h0CD, 8);
    chk("wr_upd", upd_cnt - u0, 1);
    rd(2, 3, v);
    chk("wr_cell", v, 1);
    chk("wr_err", ERR_COUNT, 0);

    u0 = upd_cnt;
    send(9'h04D, 8);
    chk("par_upd", upd_cnt - u0, 0);
    rd(2, 3, v);
    chk("par_cell", v, 1);
    chk("par_err", ERR_COUNT, 1);

    send(9'h04D, 7);
    chk("len7_err", ERR_COUNT, 2);
    send(9'h0CE, 9);
    chk("len9_err", ERR_COUNT, 3);
    rd(2, 3, v);
    chk("len9_cell", v, 1);

    u0 = upd_cnt;
    send(9'h037, 8);
    chk("col5_err", ERR_COUNT, 4);
    chk("col5_upd", upd_cnt - u0, 0);
    send(9'h0BC, 8);
    chk("row1c7_err", ERR_COUNT, 5);

    send(9'h002, 8);
    send(9'h073, 8);
    send(9'h061, 8);
    rd(0, 0, v);
    chk("fill00", v, 2);
    rd(3, 4, v);
    chk("fill34", v, 3);
    rd(3, 0, v);
    chk("fill30", v, 1);
    rd(2, 5, v);
    chk("rd_oor", v, 0);

    u0 = upd_cnt;
    send(9'h07C, 8);
    chk("done_set", DONE, 1);
    chk("done_upd", upd_cnt - u0, 0);

    u0 = upd_cnt;
    send(9'h01C, 8);
    chk("clr_upd", upd_cnt - u0, 1);
    nz = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 5; c++) begin
        rd(2'(r), 3'(c), v);
        if (v != 2'd0) nz++;
      end
    chk("clr_cells", nz, 0);
    chk("clr_done", DONE, 1);
    chk("clr_err", ERR_COUNT, 5);

    SER_EN = 1'b1;
    cyc(TMO + 20);
    chk("tmo_err", ERR_COUNT, 6);
    u0 = upd_cnt;
    bits(9'h0CD, 8);
    cyc(5);
    SER_EN = 1'b0;
    cyc(12);
    chk("drain_upd", upd_cnt - u0, 0);
    chk("drain_err", ERR_COUNT, 6);
    rd(2, 3, v);
    chk("drain_cell", v, 0);
    send(9'h0CD, 8);
    rd(2, 3, v);
    chk("post_tmo", v, 1);
    chk("done_keep", DONE, 1);

    SER_EN = 1'b1;
    cyc(6);
    bits(9'h0CD, 4);
    RESET = 1'b0;
    SER_EN = 1'b0;
    cyc(5);
    RESET = 1'b1;
    cyc(10);
    chk("mrst_err", ERR_COUNT, 0);
    chk("mrst_done", DONE, 0);
    rd(2, 3, v);
    chk("mrst_cell", v, 0);
    u0 = upd_cnt;
    send(9'h007, 8);
    rd(0, 1, v);
    chk("mrst_wr", v, 3);
    chk("mrst_upd", upd_cnt - u0, 1);

    u0 = upd_cnt;
    for (int i = 0; i < 256; i++) send(9'h04D, 8);
    chk("sat_err", ERR_COUNT, 255);
    chk("sat_upd", upd_cnt - u0, 0);
    rd(0, 1, v);
    chk("sat_cell", v, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
